// File: rtl/dmem_access_controller.sv
// Round-robin arbiter and read-modify-write sequencer for a big-endian word-wide data memory.
// Optional macro DMEM_ALIGN_CHECK_EN adds r0_error/r1_error and rejects misaligned requests.
module dmem_access_controller #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clock_enable,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_write_data,
    input  logic [3:0]        r0_byte_en,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_read_data,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_write_data,
    input  logic [3:0]        r1_byte_en,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_read_data,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic              r0_error,
    output logic              r1_error,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StMerge, StDone} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          ben_q, ben_d;
    logic [DATA_W-1:0]   merge_q, merge_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   merged;
    logic                write_strobe;
    logic                pick;
`ifdef DMEM_ALIGN_CHECK_EN
    logic                error_q, error_d;
`else
    logic                unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
`endif

    // Enabled lanes come from the store data, the rest from the word read in ACCESS.
    always_comb begin
        merged = merge_q;
        for (int i = 0; i < 4; i++) begin
            if (ben_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        ben_d          = ben_q;
        merge_d        = merge_q;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        mem_address    = '0;
        mem_read       = 1'b0;
        write_strobe   = 1'b0;
        mem_write_data = '0;
        pick           = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        error_d        = error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (r0_req || r1_req) begin
                    pick         = (r0_req && r1_req) ? !last_grant_q : r1_req;
                    grant_d      = pick;
                    last_grant_d = pick;
                    write_d      = pick ? r1_write      : r0_write;
                    addr_d       = pick ? r1_address    : r0_address;
                    wdata_d      = pick ? r1_write_data : r0_write_data;
                    ben_d        = pick ? r1_byte_en    : r0_byte_en;
                    state_d      = StAccess;
`ifdef DMEM_ALIGN_CHECK_EN
                    error_d      = (addr_d[1:0] != 2'b00);
                    if (error_d) state_d = StDone;
`endif
                end
            end
            StAccess: begin
                mem_address = {addr_q[ADDR_W-1:2], 2'b00};
                mem_read    = 1'b1;
                state_d     = StDone;
                if (!write_q) begin
                    if (grant_q) rdata1_d = mem_read_data;
                    else         rdata0_d = mem_read_data;
                end else if (ben_q == 4'b1111) begin
                    write_strobe   = 1'b1;
                    mem_write_data = wdata_q;
                end else if (ben_q != 4'b0000) begin
                    merge_d = mem_read_data;
                    state_d = StMerge;
                end
            end
            StMerge: begin
                mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
                write_strobe   = 1'b1;
                mem_write_data = merged;
                state_d        = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ben_q        <= '0;
            merge_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            error_q      <= 1'b0;
`endif
        end else if (clock_enable) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ben_q        <= ben_d;
            merge_q      <= merge_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef DMEM_ALIGN_CHECK_EN
            error_q      <= error_d;
`endif
        end
    end

    // A frozen controller must never let the memory commit a write.
    assign mem_write    = write_strobe & clock_enable;
    assign r0_ack       = (state_q == StDone) && !grant_q;
    assign r1_ack       = (state_q == StDone) && grant_q;
    assign r0_read_data = rdata0_q;
    assign r1_read_data = rdata1_q;
    assign busy         = (state_q != StIdle);
`ifdef DMEM_ALIGN_CHECK_EN
    assign r0_error     = r0_ack & error_q;
    assign r1_error     = r1_ack & error_q;
`endif

endmodule

// File: tb/tb_dmem_access_controller.sv
// Scoreboard bench for dmem_access_controller: directed cases plus random traffic on both ports.
// Define DMEM_ALIGN_CHECK_EN for bench and design together to cover the misaligned-error path.
module tb_dmem_access_controller;

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [31:0] INIT [16] = '{
        32'hFFFFFFFF, 32'h55555555, 32'h01010101, 32'hCCCCCCCC,
        32'h10203040, 32'hDEADBEEF, 32'h00000000, 32'h89ABCDEF,
        32'hA5A5A5A5, 32'h0F0F0F0F, 32'h13579BDF, 32'h2468ACE0,
        32'h11112222, 32'h33334444, 32'h76543210, 32'hFEDCBA98
    };

    logic        clk = 1'b0;
    logic        reset, clock_enable;
    logic        r0_req, r0_write, r0_ack, r1_req, r1_write, r1_ack;
    logic [31:0] r0_address, r0_write_data, r0_read_data;
    logic [31:0] r1_address, r1_write_data, r1_read_data;
    logic [3:0]  r0_byte_en, r1_byte_en;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write, busy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        r0_error, r1_error;
`endif

    logic [31:0] phys [16] = INIT;
    logic [31:0] ref_mem [16] = INIT;
    logic [31:0] model_rdata [2] = '{32'h0, 32'h0};
    logic        model_last = 1'b1;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];

    int          total = 0, bad = 0, acks0 = 0, acks1 = 0;
    int unsigned edge_cnt = 0, wr_edges = 0, act_cnt = 0;
    logic        ce_last = 1'b1;

    always #5 clk = ~clk;

    dmem_access_controller dut (
        .clk            (clk),
        .reset          (reset),
        .clock_enable   (clock_enable),
        .r0_req         (r0_req),
        .r0_write       (r0_write),
        .r0_address     (r0_address),
        .r0_write_data  (r0_write_data),
        .r0_byte_en     (r0_byte_en),
        .r0_ack         (r0_ack),
        .r0_read_data   (r0_read_data),
        .r1_req         (r1_req),
        .r1_write       (r1_write),
        .r1_address     (r1_address),
        .r1_write_data  (r1_write_data),
        .r1_byte_en     (r1_byte_en),
        .r1_ack         (r1_ack),
        .r1_read_data   (r1_read_data),
`ifdef DMEM_ALIGN_CHECK_EN
        .r0_error       (r0_error),
        .r1_error       (r1_error),
`endif
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    // Word-wide memory: combinational read, write on the rising edge.
    assign mem_read_data = phys[mem_address[5:2]];
    always @(posedge clk) if (mem_write) phys[mem_address[5:2]] <= mem_write_data;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
        if (mem_write) wr_edges++;
        ce_last = clock_enable;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, edge_cnt);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned lat_of(input txn_t t);
`ifdef DMEM_ALIGN_CHECK_EN
        if (t.a[1:0] != 2'b00) return 1;
`endif
        if (!t.wr || t.be == 4'hF || t.be == 4'h0) return 2;
        return 3;
    endfunction

    function automatic logic model_apply(input int p, input txn_t t);
        int w;
        w = int'(t.a[5:2]);
`ifdef DMEM_ALIGN_CHECK_EN
        if (t.a[1:0] != 2'b00) return 1'b1;
`endif
        // Byte k of the word (address offset k) lives in bits 31-8k downto 24-8k.
        if (!t.wr) model_rdata[p] = ref_mem[w];
        else begin
            for (int k = 0; k < 4; k++) begin
                if (t.be[3-k]) ref_mem[w][31-8*k -: 8] = t.d[31-8*k -: 8];
            end
        end
        return 1'b0;
    endfunction

    task automatic predict(input int p, input txn_t t, input int unsigned cyc);
        exp_t e;
        e.cyc   = cyc;
        e.err   = model_apply(p, t);
        e.rdata = model_rdata[p];
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        txn_t t;
        t.wr = wr; t.a = a; t.d = d; t.be = be;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr = 1'($urandom_range(0, 1));
        t.a  = $urandom;
        if ($urandom_range(0, 3) != 0) t.a[1:0] = 2'b00;
        t.d  = $urandom;
        case ($urandom_range(0, 3))
            0:       t.be = 4'hF;
            1:       t.be = 4'h0;
            default: t.be = 4'($urandom_range(1, 14));
        endcase
        return t;
    endfunction

    // ---------------- monitor ----------------
    task automatic check_ack(input int p, input logic [31:0] rd, input logic er);
        exp_t e;
        total++;
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_ack port=%0d got=1 want=0 (cycle %0d)", p, edge_cnt);
            return;
        end
        if (p == 0) begin e = exp_q0.pop_front(); acks0++; end
        else        begin e = exp_q1.pop_front(); acks1++; end
        if (edge_cnt != e.cyc) begin
            bad++;
            $display("FAIL ack_cycle port=%0d got=%0d want=%0d", p, edge_cnt, e.cyc);
        end
        chk($sformatf("read_data_p%0d", p), rd, e.rdata);
        chk($sformatf("error_p%0d", p), {31'h0, er}, {31'h0, e.err});
    endtask

    initial begin
        logic pa0, pa1, e0, e1;
        pa0 = 1'b0; pa1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pa0 = 1'b0; pa1 = 1'b0;
            end else begin
                e0 = 1'b0; e1 = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
                e0 = r0_error; e1 = r1_error;
`endif
                // An ack held by a frozen clock is the same completion, not a new one.
                if (r0_ack && !(pa0 && !ce_last)) check_ack(0, r0_read_data, e0);
                if (r1_ack && !(pa1 && !ce_last)) check_ack(1, r1_read_data, e1);
                if (mem_read || mem_write) begin
                    act_cnt++;
                    chk("mem_address_aligned", {30'h0, mem_address[1:0]}, 32'h0);
                end
                pa0 = r0_ack; pa1 = r1_ack;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_txns(input logic use0, input txn_t t0, input logic use1, input txn_t t1,
                            input int unsigned extra);
        int unsigned c;
        int          first, second, tgt0, tgt1;
        txn_t        ft, st;
        if (use0 && use1) begin
            first = model_last ? 0 : 1;
            second = 1 - first;
        end else begin
            first = use1 ? 1 : 0;
            second = -1;
        end
        ft = (first == 0) ? t0 : t1;
        st = (first == 0) ? t1 : t0;
        c = edge_cnt + lat_of(ft) + extra;
        predict(first, ft, c);
        model_last = (first == 1);
        if (second >= 0) begin
            c = c + 1 + lat_of(st);
            predict(second, st, c);
            model_last = (second == 1);
        end
        // The idle port's fields carry junk that must never leak into memory.
        r0_write = t0.wr; r0_address = use0 ? t0.a : $urandom; r0_write_data = t0.d;
        r0_byte_en = t0.be; r0_req = use0;
        r1_write = t1.wr; r1_address = use1 ? t1.a : $urandom; r1_write_data = t1.d;
        r1_byte_en = t1.be; r1_req = use1;
        tgt0 = acks0 + (use0 ? 1 : 0);
        tgt1 = acks1 + (use1 ? 1 : 0);
        for (int k = 0; k < 60 && (acks0 < tgt0 || acks1 < tgt1); k++) begin
            @(negedge clk);
            #1;
            if (acks0 >= tgt0) r0_req = 1'b0;
            if (acks1 >= tgt1) r1_req = 1'b0;
        end
        if (acks0 < tgt0 || acks1 < tgt1) begin
            total++;
            bad++;
            $display("FAIL ack_timeout got_acks=%0d/%0d want_acks=%0d/%0d",
                     acks0, acks1, tgt0, tgt1);
            r0_req = 1'b0; r1_req = 1'b0;
            exp_q0.delete(); exp_q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_last = 1'b1;
        model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w0, a0, n;
        txn_t        nul;
        nul = mk(1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1; clock_enable = 1'b1;
        r0_req = 1'b0; r0_write = 1'b0; r0_address = '0; r0_write_data = '0; r0_byte_en = '0;
        r1_req = 1'b0; r1_write = 1'b0; r1_address = '0; r1_write_data = '0; r1_byte_en = '0;
        #1;
        chk("reset_acks", {30'h0, r0_ack, r1_ack}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("reset_mem_address", mem_address, 32'h0);
        chk("reset_mem_write_data", mem_write_data, 32'h0);
        chk("reset_r0_read_data", r0_read_data, 32'h0);
        chk("reset_r1_read_data", r1_read_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain load: no write strobe may appear.
        w0 = wr_edges;
        run_txns(1'b1, mk(1'b0, 32'h4, 32'h0, 4'h0), 1'b0, nul, 0);
        chk("load_no_write", wr_edges - w0, 32'h0);

        // Partial store then read-back of the merged word.
        run_txns(1'b1, mk(1'b1, 32'h8, 32'hAABBCCDD, 4'b0100), 1'b0, nul, 0);
        run_txns(1'b1, mk(1'b0, 32'h8, 32'h0, 4'h0), 1'b0, nul, 0);
        chk("partial_store_word", r0_read_data, 32'h01BB0101);

        // Simultaneous requests after reset, twice.
        apply_reset();
        run_txns(1'b1, mk(1'b0, 32'hC, 32'h0, 4'h0), 1'b1, mk(1'b0, 32'hC, 32'h0, 4'h0), 0);
        apply_reset();
        run_txns(1'b1, mk(1'b0, 32'hC, 32'h0, 4'h0), 1'b1, mk(1'b0, 32'hC, 32'h0, 4'h0), 0);
        chk("arb_r1_data", r1_read_data, 32'hCCCCCCCC);

        // Reset while the merge write is being presented.
        r0_write = 1'b1; r0_address = 32'h0; r0_write_data = 32'h12121212; r0_byte_en = 4'b0001;
        r0_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("merge_write_strobe", {31'h0, mem_write}, 32'h1);
        reset = 1'b1;
        r0_req = 1'b0;
        #1;
        chk("reset_mid_mem_write", {31'h0, mem_write}, 32'h0);
        chk("reset_mid_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_last = 1'b1;
        model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_mid_read_data", r0_read_data, 32'h0);
        run_txns(1'b1, mk(1'b0, 32'h0, 32'h0, 4'h0), 1'b0, nul, 0);
        chk("reset_mid_mem_untouched", r0_read_data, 32'hFFFFFFFF);

        // Four-cycle freeze in ACCESS of a full-word store.
        w0 = wr_edges;
        fork
            run_txns(1'b1, mk(1'b1, 32'h4, 32'h12345678, 4'hF), 1'b0, nul, 4);
            begin
                @(posedge clk);
                #1;
                clock_enable = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_strobes", {30'h0, mem_read, mem_write}, 32'h2);
                    @(posedge clk);
                end
                #1;
                clock_enable = 1'b1;
            end
        join
        chk("stall_write_edges", wr_edges - w0, 32'h1);
        chk("stall_mem_word", phys[1], 32'h12345678);

`ifdef DMEM_ALIGN_CHECK_EN
        a0 = act_cnt;
        run_txns(1'b0, nul, 1'b1, mk(1'b0, 32'h6, 32'h0, 4'h0), 0);
        chk("misaligned_no_mem_access", act_cnt - a0, 32'h0);
`else
        a0 = 0;
`endif

        // Random traffic, single and simultaneous requests.
        for (int i = 0; i < 80; i++) begin
            n = $urandom_range(0, 2);
            run_txns(n != 1, rand_txn(), n != 0, rand_txn(), 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        for (int w = 0; w < 16; w++) chk($sformatf("final_mem_%0d", w), phys[w], ref_mem[w]);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
